// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial add/subtract unit: state encoding,
// default operand width and op_sub encodings.
package serial_addsub_pkg;

   localparam int DEFAULT_WIDTH = 32;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/Adder.sv
// 1-bit full-adder cell; the only arithmetic element of the serial datapath.
module Adder (
   input  logic a,
   input  logic b,
   input  logic carryin,
   output logic sum,
   output logic carryout
);

   assign sum      = a ^ b ^ carryin;
   assign carryout = (a & b) | (a & carryin) | (b & carryin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit add/subtract: streams operands LSB-first through one
// full-adder cell, one bit per clock, and reports result and flags with a done pulse.
module serial_addsub
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op_sub,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow,
   output logic             zero,
   output state_e           state_o
);

   localparam int               CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

   logic [1:0]       state_q,  state_d;
   logic [CNT_W-1:0] cnt_q,    cnt_d;
   logic [WIDTH-1:0] a_q,      a_d;
   logic [WIDTH-1:0] b_q,      b_d;
   logic             c_q,      c_d;
   logic [WIDTH-1:0] psum_q,   psum_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             cout_q,   cout_d;
   logic             ovf_q,    ovf_d;
   logic             zero_q,   zero_d;

   logic bit_sum;
   logic bit_cout;

   Adder u_adder (
      .a        (a_q[cnt_q]),
      .b        (b_q[cnt_q]),
      .carryin  (c_q),
      .sum      (bit_sum),
      .carryout (bit_cout)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      c_d      = c_q;
      psum_d   = psum_q;
      result_d = result_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      zero_d   = zero_q;
      case (state_q)
         ST_RUN: begin
            psum_d = {bit_sum, psum_q[WIDTH-1:1]};
            c_d    = bit_cout;
            cnt_d  = cnt_q + 1'b1;
            // On the MSB, c_q is the carry into the sign bit, so overflow is
            // formed directly from it rather than from a separate capture.
            if (cnt_q == LAST) begin
               state_d  = ST_DONE;
               result_d = psum_d;
               cout_d   = bit_cout;
               ovf_d    = c_q ^ bit_cout;
               zero_d   = (psum_d == '0);
            end
         end
         default: begin
            if (start) begin
               state_d = ST_RUN;
               a_d     = src1;
               b_d     = (op_sub == OP_SUB) ? ~src2 : src2;
               c_d     = (op_sub == OP_SUB);
               cnt_d   = '0;
               psum_d  = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= 1'b0;
         psum_q   <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         c_q      <= c_d;
         psum_q   <= psum_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
         zero_q   <= zero_d;
      end
   end

   assign busy     = (state_q == ST_RUN);
   assign done     = (state_q == ST_DONE);
   assign result   = result_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;
   assign zero     = zero_q;
   assign state_o  = state_e'(state_q);

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: scoreboard of expected results,
// latency, back-to-back, busy-start and asynchronous reset scenarios.
module tb_serial_addsub;
   import serial_addsub_pkg::*;

   localparam int W = 32;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic         op_sub;
   logic [W-1:0] src1;
   logic [W-1:0] src2;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         overflow;
   logic         zero;
   state_e       state_o;

   int total = 0;
   int bad   = 0;
   int done_cnt = 0;
   int exp_done = 0;

   // Packed as {result, cout, overflow, zero}.
   logic [W+2:0] exp_q[$];
   logic [W+2:0] hold_v = '0;

   serial_addsub #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .op_sub   (op_sub),
      .src1     (src1),
      .src2     (src2),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .cout     (cout),
      .overflow (overflow),
      .zero     (zero),
      .state_o  (state_o)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic sub);
      logic [W-1:0] bb;
      logic [W:0]   full;
      logic         v;
      bb   = sub ? ~b : b;
      full = {1'b0, a} + {1'b0, bb} + (W+1)'(sub);
      v    = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
      return {full[W-1:0], full[W], v, (full[W-1:0] == '0)};
   endfunction

   // driver: called at a negedge, holds start for exactly one sampling edge
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      src1   = a;
      src2   = b;
      op_sub = sub;
      start  = 1'b1;
      exp_q.push_back(model(a, b, sub));
      @(negedge clk);
      start  = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 40);
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      int n;
      do_op(a, b, sub);
      wait_done(n);
      exp_done++;
      chk("latency", 64'(n), 64'd32);
      chk("busy_in_done", {63'd0, busy}, 64'd0);
   endtask

   // scoreboard / monitor
   always @(negedge clk) begin
      if (!rst_n) begin
         hold_v = '0;
      end else begin
         chk("busy_and_done", {63'd0, busy & done}, 64'd0);
         if (done) begin
            done_cnt++;
            if (exp_q.size() > 0) begin
               hold_v = exp_q.pop_front();
               chk("result",   64'(result),      64'(hold_v[W+2:3]));
               chk("cout",     {63'd0, cout},     {63'd0, hold_v[2]});
               chk("overflow", {63'd0, overflow}, {63'd0, hold_v[1]});
               chk("zero",     {63'd0, zero},     {63'd0, hold_v[0]});
            end
         end else begin
            chk("result_stable", 64'({result, cout, overflow, zero}), 64'(hold_v));
         end
      end
   end

   initial begin
      int n;
      rst_n  = 1'b0;
      start  = 1'b0;
      op_sub = OP_ADD;
      src1   = '0;
      src2   = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy",   {63'd0, busy},     64'd0);
      chk("rst_done",   {63'd0, done},     64'd0);
      chk("rst_result", 64'(result),       64'd0);
      chk("rst_flags",  {61'd0, cout, overflow, zero}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op(32'd5, 32'd3, OP_ADD);
      @(negedge clk);
      run_op(32'h7FFF_FFFF, 32'h0000_0001, OP_ADD);
      @(negedge clk);
      run_op(32'hFFFF_FFFF, 32'h0000_0001, OP_ADD);
      @(negedge clk);

      // back-to-back: second start issued during the done cycle
      run_op(32'd5, 32'd5, OP_SUB);
      run_op(32'd3, 32'd5, OP_SUB);
      @(negedge clk);

      // start while busy must be ignored
      do_op(32'd1, 32'd1, OP_ADD);
      repeat (9) @(negedge clk);
      src1   = 32'd9;
      src2   = 32'd9;
      op_sub = OP_SUB;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      wait_done(n);
      exp_done++;
      repeat (40) @(negedge clk);
      chk("busy_start_done_count", 64'(done_cnt), 64'(exp_done));

      for (int i = 0; i < 6; i++) begin
         run_op($urandom, $urandom, 1'($urandom_range(0, 1)));
         @(negedge clk);
      end
      run_op(32'h8000_0000, 32'h8000_0001, OP_ADD);
      @(negedge clk);

      // asynchronous reset in the middle of a run
      do_op(32'd7, 32'd8, OP_ADD);
      repeat (15) @(negedge clk);
      chk("busy_mid_run", {63'd0, busy}, 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_busy",   {63'd0, busy},   64'd0);
      chk("async_rst_done",   {63'd0, done},   64'd0);
      chk("async_rst_result", 64'(result),     64'd0);
      chk("async_rst_flags",  {61'd0, cout, overflow, zero}, 64'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("no_done_after_reset", 64'(done_cnt), 64'(exp_done));
      run_op(32'd2, 32'd2, OP_ADD);
      @(negedge clk);
      chk("final_done_count", 64'(done_cnt), 64'(exp_done));
      chk("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Bit-serial WIDTH-bit add/subtract unit for the lab ALU datapath. Latches two operands on a start request, then streams them LSB-first through a single 1-bit full-adder cell, one bit per clock, with a registered carry. Collects the sum and reports result, carry-out, overflow and zero flags with a one-cycle done pulse. It is the sequencing stage directly upstream of the 1-bit Adder cell: it feeds that cell and consumes its sum/carry.

## Interface
- WIDTH, 32, operand/result width in bits (≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only when the block is not busy
- op_sub  in  1  0 = src1+src2, 1 = src1−src2; latched with start
- src1  in  WIDTH  operand A; latched with start
- src2  in  WIDTH  operand B; latched with start
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse when result/flags are updated
- result  out  WIDTH  sum/difference; holds until next completion
- cout  out  1  carry out of MSB (for sub: 1 = no borrow)
- overflow  out  1  signed overflow
- zero  out  1  result == 0

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE + start=1 → RUN.
  - Latch a ← src1 and b ← (op_sub ? ~src2 : src2).
  - Carry register c ← op_sub; bit counter cnt ← 0; partial-sum shift register cleared.
- RUN, each cycle:
  - Adder cell inputs: a[cnt], b[cnt], c.
  - Cell sum shifted into partial-sum register at the MSB (shift right); c ← cell carryout; cnt ← cnt+1.
  - At cnt == WIDTH−1, also capture c as cin_msb (the carry into the MSB).
- RUN with cnt == WIDTH−1 → DONE.
  - result ← final partial sum; cout ← cell carryout; overflow ← cin_msb XOR cell carryout; zero ← (final sum == 0).
- DONE, start=0 → IDLE. done = 1 only in DONE.
- start in RUN is ignored: no queueing, no effect on the operation in flight.
- src1/src2/op_sub changes during RUN are ignored.
- Width rules: cnt is $clog2(WIDTH) bits. All arithmetic is modulo 2^WIDTH; subtraction is a + ~b + 1.

## Timing
- Reset (async, any state, including mid-RUN):
  - state = IDLE, busy = 0, done = 0.
  - result = 0, cout = 0, overflow = 0, zero = 0.
  - The partial operation is discarded and no done is issued.
- Latency: start sampled at edge k → busy=1 from edge k to edge k+WIDTH. done=1 and outputs updated from edge k+WIDTH, for exactly one cycle.
- Throughput: start asserted during the done cycle is accepted, giving a new done every WIDTH cycles. Otherwise there is at least one IDLE cycle between operations.
- result/cout/overflow/zero change only at the edge that enters DONE (or at reset), and are stable at all other times.
- done and busy are never high together.

## Structure
- Shared package holds:
  - State enum {IDLE, RUN, DONE}.
  - Default width constant (32).
  - OP_ADD/OP_SUB encodings for op_sub.
- Sub-module: one instance of the team's 1-bit `Adder` cell (a, b, carryin → sum, carryout). All bit arithmetic goes through it; no parallel adder is inferred.
- Everything else (FSM, counter, operand/shift registers, flag logic) lives in serial_addsub.

## Test plan
- Add, WIDTH=32: src1=5, src2=3, op_sub=0, start 1 cycle → done exactly 32 cycles later; result=8, cout=0, overflow=0, zero=0.
- Signed overflow: 0x7FFFFFFF + 0x00000001 → result=0x80000000, overflow=1, cout=0.
- Wrap: 0xFFFFFFFF + 0x00000001 → result=0, cout=1, overflow=0, zero=1.
- Subtract, then back-to-back:
  - 5 − 5 (op_sub=1) → result=0, cout=1, zero=1.
  - New start in the done cycle with 3 − 5 → next done 32 cycles later; result=0xFFFFFFFE, cout=0, overflow=0.
- Busy-start ignored: start with 1+1; re-assert start with 9+9 at cycle 10 of RUN → result=2, done occurs once only.
- Reset mid-RUN: deassert rst_n at cycle 16 of a run → all outputs 0 immediately (asynchronous), no done; after release, a fresh 2+2 → result=4.
